// File: rtl/sobel_window_gen_if.sv
// Memory read port and window stream of the Sobel window generator.
// The master side is the generator; the slave side is memory plus the Sobel stage.
interface sobel_window_gen_if;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [31:0] mem_dataR;
    logic [71:0] win;
    logic [8:0]  win_row;
    logic [8:0]  win_col;
    logic        win_valid;
    logic        win_ready;

    modport master (
        output mem_addr, mem_en, win, win_row, win_col, win_valid,
        input  mem_dataR, win_ready
    );

    modport slave (
        input  mem_addr, mem_en, win, win_row, win_col, win_valid,
        output mem_dataR, win_ready
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Reads a packed 8-bit image four pixels per word and streams the 3x3 window
// of every interior pixel, one window per valid/ready handshake.
module sobel_window_gen #(
    parameter int IMG_W    = 352,
    parameter int IMG_H    = 288,
    parameter int SRC_BASE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               done,
    sobel_window_gen_if.master bus
);
    localparam int          WPR    = IMG_W / 4;
    localparam logic [15:0] WPR16  = 16'(WPR);
    localparam logic [15:0] BASE16 = 16'(SRC_BASE);
    localparam logic [15:0] LAST_K = 16'(WPR - 1);
    localparam logic [8:0]  LAST_R = 9'(IMG_H - 2);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RDW, EMIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [8:0]  r;
    logic [15:0] k;
    logic [1:0]  e;
    logic [15:0] ret_t, ret_m, ret_b;
    logic [31:0] new_t, new_m, new_b;
    logic [15:0] rd_row;
    logic        accept, group_end, more_k, more_r, emitting;

    assign emitting  = (state == EMIT);
    assign accept    = emitting && bus.win_ready;
    assign group_end = accept && (e == 2'd3);
    assign more_k    = (k < LAST_K);
    assign more_r    = (r < LAST_R);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and infers a latch.
        state_nxt  = state;
        bus.mem_en = 1'b0;
        rd_row     = 16'd0;
        case (state)
            IDLE, DONE: if (start) state_nxt = RD0;
            RD0: begin
                bus.mem_en = 1'b1;
                state_nxt  = RD1;
            end
            RD1: begin
                bus.mem_en = 1'b1;
                rd_row     = 16'd1;
                state_nxt  = RD2;
            end
            RD2: begin
                bus.mem_en = 1'b1;
                rd_row     = 16'd2;
                state_nxt  = RDW;
            end
            RDW:  state_nxt = EMIT;
            EMIT: if (group_end) state_nxt = (more_k || more_r) ? RD0 : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_addr = bus.mem_en ? BASE16 + ({7'd0, r} - 16'd1 + rd_row) * WPR16 + k : 16'd0;

    // Column store: slots 0..1 hold columns 4k-2..4k-1, slots 2..5 hold columns 4k..4k+3.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the pixel store is small register state, so it is reset with everything else and never exposes stale data after an abort.
        if (reset) begin
            r     <= '0;
            k     <= '0;
            e     <= '0;
            ret_t <= '0;
            ret_m <= '0;
            ret_b <= '0;
            new_t <= '0;
            new_m <= '0;
            new_b <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r <= 9'd1;
                        k <= '0;
                    end
                end
                RD1: new_t <= bus.mem_dataR;
                RD2: new_m <= bus.mem_dataR;
                RDW: begin
                    new_b <= bus.mem_dataR;
                    e     <= (k == 16'd0) ? 2'd2 : 2'd0;
                end
                EMIT: begin
                    if (accept) begin
                        e <= e + 2'd1;
                        if (e == 2'd3) begin
                            if (more_k) begin
                                k     <= k + 16'd1;
                                ret_t <= new_t[31:16];
                                ret_m <= new_m[31:16];
                                ret_b <= new_b[31:16];
                            end else if (more_r) begin
                                r <= r + 9'd1;
                                k <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [47:0] row_t, row_m, row_b;
    logic [71:0] win_raw;
    logic [8:0]  col_raw;

    assign row_t   = {new_t, ret_t};
    assign row_m   = {new_m, ret_m};
    assign row_b   = {new_b, ret_b};
    assign col_raw = {k[6:0], 2'b00} + {7'd0, e} - 9'd1;

    // Emit index e selects store slots e, e+1, e+2 as the window's left..right columns.
    always_comb begin
        win_raw = '0;
        for (int j = 0; j < 3; j++) begin
            win_raw[8*j     +: 8] = row_t[8*(int'(e)+j) +: 8];
            win_raw[8*(3+j) +: 8] = row_m[8*(int'(e)+j) +: 8];
            win_raw[8*(6+j) +: 8] = row_b[8*(int'(e)+j) +: 8];
        end
    end

    assign bus.win_valid = emitting;
    assign bus.win       = emitting ? win_raw : 72'd0;
    assign bus.win_row   = emitting ? r : 9'd0;
    assign bus.win_col   = emitting ? col_raw : 9'd0;
    assign done          = (state == DONE);
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench: 8x4 image with a hand-built window table, plus a 16x5 random
// image at a non-zero base checked against a pixel-level model.
module tb_sobel_window_gen;
    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b, done_a, done_b;

    sobel_window_gen_if bus_a ();
    sobel_window_gen_if bus_b ();

    sobel_window_gen #(.IMG_W(8), .IMG_H(4), .SRC_BASE(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .done(done_a), .bus(bus_a)
    );
    sobel_window_gen #(.IMG_W(16), .IMG_H(5), .SRC_BASE(100)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_a [0:7];
    logic [31:0] mem_b [0:255];

    always @(posedge clk) begin
        if (bus_a.mem_en)
            bus_a.mem_dataR <= (bus_a.mem_addr < 16'd8) ? mem_a[bus_a.mem_addr[2:0]] : 32'hDEAD_BEEF;
        if (bus_b.mem_en)
            bus_b.mem_dataR <= (bus_b.mem_addr < 16'd256) ? mem_b[bus_b.mem_addr[7:0]] : 32'hDEAD_BEEF;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         stall;
        logic [8:0] row;
        logic [8:0] col;
        logic [7:0] s11;
        logic [7:0] s22;
        logic [7:0] s33;
    } vec_t;

    vec_t        tbl [12];
    logic [15:0] exp_addr [12];

    function automatic logic [71:0] exp_win_a(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = 8'((r - 1 + i) * 16 + (c - 1 + j));
        return w;
    endfunction

    function automatic logic [7:0] pix_b(input int r, input int c);
        logic [31:0] word;
        word = mem_b[100 + r * 4 + c / 4];
        return word[8*(c % 4) +: 8];
    endfunction

    function automatic logic [71:0] exp_win_b(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = pix_b(r - 1 + i, c - 1 + j);
        return w;
    endfunction

    // Runs one frame of the 8x4 image; entered and left just after a falling edge.
    task automatic run_small(input bit use_stall, input bit poke_start, input int abort_at, input string tag);
        int          n = 0;
        int          cyc = 0;
        int          last_acc = -10;
        int          stall_left = 0;
        bit          seen = 0;
        bit          got_done = 0;
        bit          poked = 0;
        bit          aborted = 0;
        logic [71:0] snap = '0;
        logic [15:0] addrs [$];

        start_a = 1'b1;
        bus_a.win_ready = 1'b1;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (cyc == 1) check({tag, " done cleared"}, done_a, 1'b0);
            if (bus_a.mem_en) addrs.push_back(bus_a.mem_addr);
            if (abort_at != 0 && n == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, " rst mem_en"}, bus_a.mem_en, 1'b0);
                check({tag, " rst mem_addr"}, bus_a.mem_addr, 16'd0);
                check({tag, " rst win"}, bus_a.win, 72'd0);
                check({tag, " rst win_row"}, bus_a.win_row, 9'd0);
                check({tag, " rst win_col"}, bus_a.win_col, 9'd0);
                check({tag, " rst win_valid"}, bus_a.win_valid, 1'b0);
                check({tag, " rst done"}, done_a, 1'b0);
                #1 reset = 1'b0;
                @(negedge clk);
                aborted = 1;
                break;
            end
            if (done_a) begin
                got_done = 1;
                check({tag, " done one cycle after last accept"}, 72'(cyc - last_acc), 72'd1);
                check({tag, " valid low with done"}, bus_a.win_valid, 1'b0);
            end else if (bus_a.win_valid) begin
                if (!seen) begin
                    seen = 1;
                    snap = bus_a.win;
                    if (n < 12) begin
                        check({tag, " win_row"}, bus_a.win_row, tbl[n].row);
                        check({tag, " win_col"}, bus_a.win_col, tbl[n].col);
                        check({tag, " s11"}, bus_a.win[7:0], tbl[n].s11);
                        check({tag, " s22"}, bus_a.win[39:32], tbl[n].s22);
                        check({tag, " s33"}, bus_a.win[71:64], tbl[n].s33);
                        check({tag, " win"}, bus_a.win, exp_win_a(int'(tbl[n].row), int'(tbl[n].col)));
                        if (use_stall && tbl[n].stall > 0) begin
                            stall_left = tbl[n].stall;
                            bus_a.win_ready = 1'b0;
                        end
                    end else begin
                        check({tag, " extra window"}, 72'(n), 72'd11);
                    end
                end else begin
                    check({tag, " stall win held"}, bus_a.win, snap);
                    check({tag, " stall row held"}, bus_a.win_row, 9'd1);
                    check({tag, " stall col held"}, bus_a.win_col, 9'd3);
                    check({tag, " stall no read"}, bus_a.mem_en, 1'b0);
                    stall_left--;
                    if (stall_left <= 0) bus_a.win_ready = 1'b1;
                end
                if (poke_start && !poked && n == 6) begin
                    start_a = 1'b1;
                    poked = 1;
                end
                if (bus_a.win_ready) begin
                    n++;
                    seen = 0;
                    last_acc = cyc;
                end
            end
        end
        bus_a.win_ready = 1'b1;
        if (!aborted) begin
            check({tag, " done reached"}, got_done, 1'b1);
            check({tag, " window count"}, 72'(n), 72'd12);
            check({tag, " frame cycles"}, 72'(cyc), use_stall ? 72'd32 : 72'd29);
            check({tag, " read count"}, 72'(addrs.size()), 72'd12);
            for (int i = 0; i < 12 && i < addrs.size(); i++)
                check({tag, " read addr"}, addrs[i], exp_addr[i]);
        end
    endtask

    // Runs one frame of the 16x5 image at base 100 against the pixel model.
    task automatic run_mid(input bit random_ready, input string tag);
        int          n = 0;
        int          cyc = 0;
        int          er = 1;
        int          ec = 1;
        int          last_row = 0;
        int          last_col = 0;
        bit          got_done = 0;
        logic [15:0] last_addr = '0;

        start_b = 1'b1;
        bus_b.win_ready = 1'b1;
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_b = 1'b0;
            if (bus_b.mem_en) last_addr = bus_b.mem_addr;
            if (random_ready) bus_b.win_ready = ($urandom_range(3) != 0);
            if (done_b) begin
                got_done = 1;
            end else if (bus_b.win_valid && bus_b.win_ready) begin
                check({tag, " win_row"}, bus_b.win_row, 9'(er));
                check({tag, " win_col"}, bus_b.win_col, 9'(ec));
                check({tag, " win"}, bus_b.win, exp_win_b(er, ec));
                last_row = int'(bus_b.win_row);
                last_col = int'(bus_b.win_col);
                n++;
                ec++;
                if (ec > 14) begin
                    ec = 1;
                    er++;
                end
            end
        end
        bus_b.win_ready = 1'b1;
        check({tag, " done reached"}, got_done, 1'b1);
        check({tag, " window count"}, 72'(n), 72'd42);
        check({tag, " last row"}, 72'(last_row), 72'd3);
        check({tag, " last col"}, 72'(last_col), 72'd14);
        check({tag, " last read addr"}, last_addr, 16'd119);
        if (!random_ready) check({tag, " frame cycles"}, 72'(cyc), 72'd91);
    endtask

    initial begin
        tbl[0]  = '{0, 9'd1, 9'd1, 8'h00, 8'h11, 8'h22};
        tbl[1]  = '{0, 9'd1, 9'd2, 8'h01, 8'h12, 8'h23};
        tbl[2]  = '{3, 9'd1, 9'd3, 8'h02, 8'h13, 8'h24};
        tbl[3]  = '{0, 9'd1, 9'd4, 8'h03, 8'h14, 8'h25};
        tbl[4]  = '{0, 9'd1, 9'd5, 8'h04, 8'h15, 8'h26};
        tbl[5]  = '{0, 9'd1, 9'd6, 8'h05, 8'h16, 8'h27};
        tbl[6]  = '{0, 9'd2, 9'd1, 8'h10, 8'h21, 8'h32};
        tbl[7]  = '{0, 9'd2, 9'd2, 8'h11, 8'h22, 8'h33};
        tbl[8]  = '{0, 9'd2, 9'd3, 8'h12, 8'h23, 8'h34};
        tbl[9]  = '{0, 9'd2, 9'd4, 8'h13, 8'h24, 8'h35};
        tbl[10] = '{0, 9'd2, 9'd5, 8'h14, 8'h25, 8'h36};
        tbl[11] = '{0, 9'd2, 9'd6, 8'h15, 8'h26, 8'h37};
        exp_addr = '{16'd0, 16'd2, 16'd4, 16'd1, 16'd3, 16'd5,
                     16'd2, 16'd4, 16'd6, 16'd3, 16'd5, 16'd7};

        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 2; k++)
                for (int m = 0; m < 4; m++)
                    mem_a[r*2+k][8*m +: 8] = 8'(r * 16 + 4 * k + m);
        for (int i = 0; i < 256; i++) mem_b[i] = $urandom;

        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.win_ready = 1'b1;
        bus_b.win_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset mem_en", bus_a.mem_en, 1'b0);
        check("reset mem_addr", bus_a.mem_addr, 16'd0);
        check("reset win", bus_a.win, 72'd0);
        check("reset win_valid", bus_a.win_valid, 1'b0);
        check("reset done", done_a, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_small(1'b0, 1'b0, 0, "base");
        repeat (3) @(negedge clk);
        check("done held until start", done_a, 1'b1);
        run_small(1'b0, 1'b0, 0, "restart");
        run_small(1'b1, 1'b0, 0, "stall");
        run_small(1'b0, 1'b1, 0, "busy start");
        run_small(1'b0, 1'b0, 5, "abort");
        run_small(1'b0, 1'b0, 0, "after abort");

        run_mid(1'b0, "mid");
        run_mid(1'b1, "mid random ready");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
